// File: rtl/clk_pkg.sv
// Shared definitions for the clock-manager lock sequencer: FSM encoding,
// parameter legality limits and counter sizing.
package clk_pkg;

    typedef enum logic [1:0] {
        ASSERT_RST = 2'd0,
        WAIT_LOCK  = 2'd1,
        RUN        = 2'd2,
        FAULT      = 2'd3
    } seqState_t;

    localparam int unsigned MAX_STAGES      = 8;
    localparam int unsigned MAX_RETRY_LIMIT = 15;
    localparam int unsigned SYNC_DEPTH      = 2;
    localparam int unsigned STAGE_IDX_W     = 3;
    localparam int unsigned RETRY_W         = 4;

    // Bits needed for a counter that runs 0..limit-1.
    function automatic int unsigned cntWidth(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing one raw clock-manager lock flag into clk.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic lockRaw,
    output logic lockSynced
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta       <= 1'b0;
            lockSynced <= 1'b0;
        end else begin
            meta       <= lockRaw;
            lockSynced <= meta;
        end
    end

endmodule

// File: rtl/clk_lock_sequencer.sv
// Brings a cascade of clock managers out of reset one stage at a time,
// qualifies each lock, retries on timeout and restarts from the lowest lost stage.
module clk_lock_sequencer
    import clk_pkg::*;
#(
    parameter int unsigned NUM_STAGES          = 2,
    parameter int unsigned RST_PULSE_CYCLES    = 4,
    parameter int unsigned LOCK_STABLE_CYCLES  = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_RETRIES         = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_STAGES-1:0]  lockedIn,
    output logic [NUM_STAGES-1:0]  stageRst,
    output logic                   allLocked,
    output logic                   fault,
    output logic                   lockLost,
    output logic [STAGE_IDX_W-1:0] activeStage,
    output logic [RETRY_W-1:0]     retryCount
);

    if (NUM_STAGES == 0 || NUM_STAGES > MAX_STAGES) begin : gBadStages
        $error("clk_lock_sequencer: NUM_STAGES must be 1..8");
    end
    if (RST_PULSE_CYCLES == 0) begin : gBadRstPulse
        $error("clk_lock_sequencer: RST_PULSE_CYCLES must be >= 1");
    end
    if (LOCK_STABLE_CYCLES == 0) begin : gBadStable
        $error("clk_lock_sequencer: LOCK_STABLE_CYCLES must be >= 1");
    end
    if (LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES) begin : gBadTimeout
        $error("clk_lock_sequencer: LOCK_TIMEOUT_CYCLES must exceed LOCK_STABLE_CYCLES");
    end
    if (MAX_RETRIES > MAX_RETRY_LIMIT) begin : gBadRetries
        $error("clk_lock_sequencer: MAX_RETRIES must be 0..15");
    end

    localparam int unsigned RST_W    = cntWidth(RST_PULSE_CYCLES);
    localparam int unsigned WAIT_W   = cntWidth(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned STABLE_W = cntWidth(LOCK_STABLE_CYCLES);

    localparam logic [RST_W-1:0]       RST_LAST    = RST_W'(RST_PULSE_CYCLES - 1);
    localparam logic [WAIT_W-1:0]      WAIT_LAST   = WAIT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STABLE_W-1:0]    STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STAGE_IDX_W-1:0] LAST_STAGE  = STAGE_IDX_W'(NUM_STAGES - 1);
    localparam logic [RETRY_W-1:0]     RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    seqState_t               state, stateNext;
    logic [NUM_STAGES-1:0]   syncedLock;
    logic [RST_W-1:0]        rstCnt, rstCntNext;
    logic [WAIT_W-1:0]       waitCnt, waitCntNext;
    logic [STABLE_W-1:0]     stableCnt, stableCntNext;
    logic [STAGE_IDX_W-1:0]  activeNext, lowerIdx, lostIdx;
    logic [RETRY_W-1:0]      retryNext;
    logic [NUM_STAGES-1:0]   stageRstNext;
    logic                    allLockedNext, faultNext, lockLostNext;
    logic                    curLock, lowerLost, anyLost, lockCounting;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : gSync
        lock_sync uSync (
            .clk        (clk),
            .rst        (rst),
            .lockRaw    (lockedIn[g]),
            .lockSynced (syncedLock[g])
        );
    end

    // Lock of the active stage, plus lowest lost stage overall and below the active one.
    always_comb begin
        curLock   = 1'b0;
        lowerLost = 1'b0;
        lowerIdx  = '0;
        anyLost   = 1'b0;
        lostIdx   = '0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            if (STAGE_IDX_W'(i) == activeStage) begin
                curLock = syncedLock[i];
            end
            if (!syncedLock[i]) begin
                anyLost = 1'b1;
                lostIdx = STAGE_IDX_W'(i);
                if (STAGE_IDX_W'(i) < activeStage) begin
                    lowerLost = 1'b1;
                    lowerIdx  = STAGE_IDX_W'(i);
                end
            end
        end
    end

    // Next state, counters and the values the output registers take next.
    always_comb begin
        stateNext     = state;
        activeNext    = activeStage;
        retryNext     = retryCount;
        rstCntNext    = '0;
        waitCntNext   = '0;
        stableCntNext = '0;
        lockLostNext  = 1'b0;
        // The first SYNC_DEPTH cycles after release still carry pre-release samples.
        lockCounting  = curLock && (32'(waitCnt) >= SYNC_DEPTH);

        unique case (state)
            ASSERT_RST: begin
                if (rstCnt == RST_LAST) begin
                    stateNext = WAIT_LOCK;
                end else begin
                    rstCntNext = rstCnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lowerLost) begin
                    stateNext  = ASSERT_RST;
                    activeNext = lowerIdx;
                    retryNext  = '0;
                end else if (lockCounting && stableCnt == STABLE_LAST) begin
                    retryNext = '0;
                    if (activeStage == LAST_STAGE) begin
                        stateNext = RUN;
                    end else begin
                        stateNext  = ASSERT_RST;
                        activeNext = activeStage + 1'b1;
                    end
                end else if (waitCnt == WAIT_LAST) begin
                    if (retryCount == RETRY_MAX) begin
                        stateNext = FAULT;
                    end else begin
                        stateNext = ASSERT_RST;
                        retryNext = retryCount + 1'b1;
                    end
                end else begin
                    waitCntNext   = waitCnt + 1'b1;
                    stableCntNext = lockCounting ? stableCnt + 1'b1 : '0;
                end
            end
            RUN: begin
                if (anyLost) begin
                    lockLostNext = 1'b1;
                    stateNext    = ASSERT_RST;
                    activeNext   = lostIdx;
                    retryNext    = '0;
                end
            end
            FAULT: begin
                stateNext = FAULT;
            end
        endcase

        stageRstNext = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            unique case (stateNext)
                ASSERT_RST: stageRstNext[i] = (STAGE_IDX_W'(i) >= activeNext);
                WAIT_LOCK:  stageRstNext[i] = (STAGE_IDX_W'(i) > activeNext);
                RUN:        stageRstNext[i] = 1'b0;
                FAULT:      stageRstNext[i] = 1'b1;
            endcase
        end
        allLockedNext = (stateNext == RUN);
        faultNext     = (stateNext == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ASSERT_RST;
            activeStage <= '0;
            retryCount  <= '0;
            rstCnt      <= '0;
            waitCnt     <= '0;
            stableCnt   <= '0;
            stageRst    <= '1;
            allLocked   <= 1'b0;
            fault       <= 1'b0;
            lockLost    <= 1'b0;
        end else begin
            state       <= stateNext;
            activeStage <= activeNext;
            retryCount  <= retryNext;
            rstCnt      <= rstCntNext;
            waitCnt     <= waitCntNext;
            stableCnt   <= stableCntNext;
            stageRst    <= stageRstNext;
            allLocked   <= allLockedNext;
            fault       <= faultNext;
            lockLost    <= lockLostNext;
        end
    end

endmodule
